wb_stage: RTL and testbench

- Writeback stage. Consumes the MEM/WB pipeline latch outputs: instruction, ALU result, memory data, status flag/value, link value.
- Drives the single register-file write port. Computes register index, data and enable for every retiring instruction.
- Instructions needing two register writes (ALU overflow: rd and status register) are serialized over two cycles. A one-cycle stall is asserted upstream while this happens.
- Keeps a retired-instruction counter for debug/perf.

---
 rtl/wb_stage.sv | 86 ++++++++
 tb/tb_wb_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving the register-file write port.
// Serializes overflow double writes over two cycles and counts retired instructions.
module wb_stage #(
    parameter int STATUS_REG  = 30,
    parameter int LINK_REG    = 31,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            ir_in,
    input  logic [31:0]            o_in,
    input  logic [31:0]            d_in,
    input  logic                   isRStatus_in,
    input  logic [31:0]            rStatus_in,
    input  logic [31:0]            r31_in,
    output logic                   ctrl_writeEnable,
    output logic [4:0]             ctrl_writeReg,
    output logic [31:0]            data_writeReg,
    output logic                   stall,
    output logic [COUNT_WIDTH-1:0] retired_count
);
    localparam logic [4:0] SREG = 5'(STATUS_REG);
    localparam logic [4:0] LREG = 5'(LINK_REG);

    typedef enum logic {RUN, SECOND} state_t;

    state_t                 state_q;
    logic                   we_q, we_d;
    logic [4:0]             reg_q, reg_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            pend_q;
    logic [COUNT_WIDTH-1:0] cnt_q;

    logic [4:0]  op, rd, prim_reg;
    logic [31:0] prim_data;
    logic        is_alu, is_lw, is_jal, is_setx, prim_we, dbl, dbl_r0;

    always_comb begin
        op        = ir_in[31:27];
        rd        = ir_in[26:22];
        is_alu    = op == 5'b00000 || op == 5'b00101;
        is_lw     = op == 5'b01000;
        is_jal    = op == 5'b00011;
        is_setx   = op == 5'b10101;
        prim_reg  = is_jal ? LREG : is_setx ? SREG : rd;
        prim_data = is_lw ? d_in : is_jal ? r31_in : is_setx ? {5'b0, ir_in[26:0]} : o_in;
        prim_we   = (is_alu || is_lw || is_jal || is_setx) && prim_reg != 5'd0;
        dbl       = is_alu && isRStatus_in;
        dbl_r0    = dbl && rd == 5'd0;
        stall     = !reset && state_q == RUN && dbl && rd != 5'd0;
        // A double write to r0 collapses into the status write alone.
        we_d      = state_q == SECOND || dbl_r0 || prim_we;
        reg_d     = (state_q == SECOND || dbl_r0) ? SREG : prim_reg;
        data_d    = state_q == SECOND ? pend_q : dbl_r0 ? rStatus_in : prim_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            we_q    <= 1'b0;
            reg_q   <= 5'd0;
            data_q  <= 32'd0;
            pend_q  <= 32'd0;
            cnt_q   <= '0;
        end else begin
            we_q   <= we_d;
            reg_q  <= reg_d;
            data_q <= data_d;
            if (state_q == RUN) begin
                if (stall) begin
                    state_q <= SECOND;
                    pend_q  <= rStatus_in;
                end
                if (ir_in != 32'd0)
                    cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end else begin
                state_q <= RUN;
            end
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;
    assign retired_count    = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; expected writes are queued by the
// stimulus and popped by a monitor whenever the write port is enabled.
module tb_wb_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir_in = 0, o_in = 0, d_in = 0, rStatus_in = 0, r31_in = 0;
    logic        isRStatus_in = 1'b0;
    logic        ctrl_writeEnable, stall;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg, retired_count;

    int tests = 0, fails = 0;
    int exp_cnt = 0;
    logic [36:0] sb[$];

    wb_stage dut (
        .clock(clock), .reset(reset), .ir_in(ir_in), .o_in(o_in), .d_in(d_in),
        .isRStatus_in(isRStatus_in), .rStatus_in(rStatus_in), .r31_in(r31_in),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .stall(stall), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every enabled write must match the oldest queued expectation.
    initial forever begin
        @(posedge clock);
        #1;
        if (ctrl_writeEnable === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got reg %0d data %h expected none",
                         ctrl_writeReg, data_writeReg);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("write_reg", {27'd0, ctrl_writeReg}, {27'd0, e[36:32]});
                chk("write_data", data_writeReg, e[31:0]);
            end
        end
    end

    // Present one instruction; if a stall is expected, hold it for the second cycle.
    task automatic issue(input logic [31:0] ir, o, d, input logic isr,
                         input logic [31:0] rs, r31, input logic exp_stall);
        @(negedge clock);
        ir_in = ir; o_in = o; d_in = d; isRStatus_in = isr; rStatus_in = rs; r31_in = r31;
        #1;
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        if (ir != 0) exp_cnt++;
        if (exp_stall) begin
            @(negedge clock);
            #1;
            chk("stall_second", {31'd0, stall}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ir_in = 0; o_in = 0; d_in = 0; isRStatus_in = 0; rStatus_in = 0; r31_in = 0;
            #1;
            chk("idle_stall", {31'd0, stall}, 32'd0);
        end
        chk("retired_count", retired_count, exp_cnt);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        chk("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        idle(3);
        chk("nop_we", {31'd0, ctrl_writeEnable}, 32'd0);

        sb.push_back({5'd5, 32'h7});
        issue(32'd5 << 22, 32'h7, 0, 0, 0, 0, 0);
        sb.push_back({5'd3, 32'hDEADBEEF});
        issue((32'd8 << 27) | (32'd3 << 22), 32'h55, 32'hDEADBEEF, 0, 0, 0, 0);
        sb.push_back({5'd31, 32'h40});
        issue(32'd3 << 27, 0, 0, 0, 0, 32'h40, 0);
        sb.push_back({5'd30, 32'h123});
        issue((32'd21 << 27) | 32'h123, 0, 0, 0, 0, 0, 0);
        idle(1);

        sb.push_back({5'd4, 32'h80000000});
        sb.push_back({5'd30, 32'h1});
        issue(32'd4 << 22, 32'h80000000, 0, 1, 32'h1, 0, 1);
        sb.push_back({5'd7, 32'h9});
        issue((32'd5 << 27) | (32'd7 << 22), 32'h9, 0, 0, 0, 0, 0);
        idle(1);

        issue(32'd5 << 27, 32'h5, 0, 0, 0, 0, 0);
        sb.push_back({5'd30, 32'h3});
        issue(32'd1 << 17, 32'h80000000, 0, 1, 32'h3, 0, 0);
        idle(2);

        sb.push_back({5'd6, 32'hAA});
        @(negedge clock);
        ir_in = 32'd6 << 22; o_in = 32'hAA; isRStatus_in = 1; rStatus_in = 32'h9;
        #1;
        chk("stall_pre_reset", {31'd0, stall}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("async_reg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("async_data", data_writeReg, 32'd0);
        chk("async_cnt", retired_count, 32'd0);
        chk("async_stall", {31'd0, stall}, 32'd0);
        exp_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        ir_in = 32'd5 << 22; o_in = 32'h11; isRStatus_in = 0; rStatus_in = 0;
        exp_cnt++;
        sb.push_back({5'd5, 32'h11});
        idle(3);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_writes: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
